// File: rtl/infer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// infer_sequencer_pkg
// Shared constants for the inference sequencer and the network wrapper it
// drives: command opcodes, wrapper status codes, the bit layout of the info
// command's data field, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package infer_sequencer_pkg;

  // Command opcodes (wrapper opcode_i)
  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INFO  = 2'd2;

  // Wrapper status codes (wrapper status_o)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Info command data layout: length in [7:0], settle count in [17:10]
  localparam int INFO_LEN_LSB = 0;
  localparam int INFO_LEN_W   = 8;
  localparam int INFO_SET_LSB = 10;
  localparam int INFO_SET_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INFO,
    S_WAIT,
    S_OUT
  } state_e;

endpackage : infer_sequencer_pkg

// File: rtl/infer_sequencer.sv
// -----------------------------------------------------------------------------
// infer_sequencer
// Upstream command sequencer for the network wrapper. Streams one frame of
// spike words into the wrapper as write commands, issues a single info
// command (frame length + settle count), waits for the wrapper to leave busy
// (bounded by a watchdog) and presents the captured result downstream.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   cfg_settle                extra settle cycles, sampled in INFO
//   s_valid/s_ready/s_data/s_last   frame word input stream
//   cmd_opcode_o, cmd_data_o  registered command port to the wrapper
//   status_i, result_i        wrapper status and result
//   m_valid/m_ready           result output handshake
//   m_result, m_settled, m_overflow, m_timeout   result and flags
//   busy_o                    sequencer not idle
// -----------------------------------------------------------------------------
module infer_sequencer
  import infer_sequencer_pkg::*;
#(
  parameter int DATA_W   = 19,
  parameter int DEPTH    = 128,
  parameter int RESULT_W = 7,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          cfg_settle,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic [1:0]          cmd_opcode_o,
  output logic [DATA_W-1:0]   cmd_data_o,
  input  logic [1:0]          status_i,
  input  logic [RESULT_W-1:0] result_i,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RESULT_W-1:0] m_result,
  output logic                m_settled,
  output logic                m_overflow,
  output logic                m_timeout,
  output logic                busy_o
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      DEPTH_C   = 8'(DEPTH);
  localparam logic [WD_W-1:0] WD_LAST_C = WD_W'(TIMEOUT - 1);

  state_e              state_q,    state_d;
  logic [7:0]          wcount_q,   wcount_d;
  logic [WD_W-1:0]     wd_q,       wd_d;
  logic [1:0]          cmd_opcode_q, cmd_opcode_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
  logic [RESULT_W-1:0] result_q,   result_d;
  logic                settled_q,  settled_d;
  logic                overflow_q, overflow_d;
  logic                timeout_q,  timeout_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wcount_d     = wcount_q;
    wd_d         = wd_q;
    cmd_opcode_d = OP_IDLE;
    cmd_data_d   = '0;
    result_d     = result_q;
    settled_d    = settled_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        // One-cycle bubble: the first beat is only accepted in LOAD.
        if (s_valid) state_d = S_LOAD;
      end

      S_LOAD: begin
        if (s_valid) begin
          if (wcount_q < DEPTH_C) begin
            cmd_opcode_d = OP_WRITE;
            cmd_data_d   = s_data;
            wcount_d     = wcount_q + 8'd1;
          end else begin
            overflow_d = 1'b1;
          end
          if (s_last) state_d = S_INFO;
        end
      end

      S_INFO: begin
        // A wrapper still busy from an aborted frame would drop the info
        // command, so hold here until it is no longer busy.
        if (status_i != ST_BUSY) begin
          cmd_opcode_d = OP_INFO;
          cmd_data_d[INFO_LEN_LSB +: INFO_LEN_W] = wcount_q;
          cmd_data_d[INFO_SET_LSB +: INFO_SET_W] = cfg_settle;
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The first WAIT cycle is the one where the info command sits on the
        // bus; the wrapper has not reacted yet, so status is ignored then.
        if (cmd_opcode_q != OP_INFO) begin
          if (status_i != ST_BUSY) begin
            result_d  = result_i;
            settled_d = (status_i == ST_DONE);
            state_d   = S_OUT;
          end else if (wd_q == WD_LAST_C) begin
            result_d  = result_i;
            settled_d = 1'b0;
            timeout_d = 1'b1;
            state_d   = S_OUT;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        if (m_ready) begin
          settled_d  = 1'b0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
          wcount_d   = '0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      wcount_q     <= '0;
      wd_q         <= '0;
      cmd_opcode_q <= OP_IDLE;
      cmd_data_q   <= '0;
      result_q     <= '0;
      settled_q    <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcount_q     <= wcount_d;
      wd_q         <= wd_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_data_q   <= cmd_data_d;
      result_q     <= result_d;
      settled_q    <= settled_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
    end
  end

  assign s_ready      = (state_q == S_LOAD);
  assign cmd_opcode_o = cmd_opcode_q;
  assign cmd_data_o   = cmd_data_q;
  assign m_valid      = (state_q == S_OUT);
  assign m_result     = result_q;
  assign m_settled    = settled_q;
  assign m_overflow   = overflow_q;
  assign m_timeout    = timeout_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule : infer_sequencer

// File: tb/tb_infer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_infer_sequencer
// Directed bench for infer_sequencer with a small behavioural wrapper model.
// The DUT runs with TIMEOUT=16 so the watchdog case stays short.
// -----------------------------------------------------------------------------
module tb_infer_sequencer;
  import infer_sequencer_pkg::*;

  localparam int DATA_W   = 19;
  localparam int DEPTH    = 128;
  localparam int RESULT_W = 7;
  localparam int TIMEOUT  = 16;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [7:0]          cfg_settle = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data = '0;
  logic                s_last = 1'b0;
  logic [1:0]          cmd_opcode_o;
  logic [DATA_W-1:0]   cmd_data_o;
  logic [1:0]          status_i;
  logic [RESULT_W-1:0] result_i;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [RESULT_W-1:0] m_result;
  logic                m_settled;
  logic                m_overflow;
  logic                m_timeout;
  logic                busy_o;

  infer_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RESULT_W(RESULT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_settle(cfg_settle),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cmd_opcode_o(cmd_opcode_o), .cmd_data_o(cmd_data_o),
    .status_i(status_i), .result_i(result_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .m_settled(m_settled), .m_overflow(m_overflow), .m_timeout(m_timeout),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // ---------------- wrapper model ----------------
  int                  busy_len = 0;
  logic [1:0]          done_st  = ST_DONE;
  logic [RESULT_W-1:0] res_val  = '0;
  logic                stuck    = 1'b0;
  int                  wr_cnt_down;

  always @(posedge clk) begin
    if (!rstn) begin
      status_i    <= ST_IDLE;
      result_i    <= '0;
      wr_cnt_down <= 0;
    end else if (cmd_opcode_o == OP_INFO) begin
      if (stuck) begin
        status_i <= ST_BUSY;
      end else if (busy_len == 0) begin
        status_i <= done_st;
        result_i <= res_val;
      end else begin
        status_i    <= ST_BUSY;
        wr_cnt_down <= busy_len;
      end
    end else if (status_i == ST_BUSY && !stuck) begin
      if (wr_cnt_down == 1) begin
        status_i <= done_st;
        result_i <= res_val;
      end
      wr_cnt_down <= wr_cnt_down - 1;
    end
  end

  // ---------------- command monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0] info_q[$];
  int                info_cyc;
  int                wr_at_info;

  always @(negedge clk) begin
    if (cmd_opcode_o == OP_WRITE) wr_q.push_back(cmd_data_o);
    if (cmd_opcode_o == OP_INFO) begin
      info_q.push_back(cmd_data_o);
      info_cyc   = cyc;
      wr_at_info = wr_q.size();
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int n, input logic [DATA_W-1:0] base);
    int i = 0;
    int guard = 0;
    wr_q.delete();
    info_q.delete();
    while (i < n && guard < 2000) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = base + DATA_W'(i);
      s_last  = (i == n - 1);
      if (s_ready) i++;
      guard++;
    end
    if (i < n) check("frame_accept", 32'(i), 32'(n));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    int k = 0;
    c = -1;
    while (k < 500) begin
      if (m_valid) begin
        c = cyc;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (c < 0) check("m_valid_wait", 32'(m_valid), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [DATA_W-1:0] base);
    int bad = 0;
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(n));
    foreach (wr_q[i]) if (wr_q[i] !== base + DATA_W'(i)) bad++;
    check({tag, "_wr_data_errs"}, 32'(bad), 32'd0);
    check({tag, "_info_count"}, 32'(info_q.size()), 32'd1);
    check({tag, "_writes_before_info"}, 32'(wr_at_info), 32'(n));
  endtask

  task automatic release_out();
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  int vcyc;

  initial begin
    // ---------- reset state ----------
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy_o),       32'd0);
    check("rst_opcode",   32'(cmd_opcode_o), 32'd0);
    check("rst_data",     32'(cmd_data_o),   32'd0);
    check("rst_m_valid",  32'(m_valid),      32'd0);
    check("rst_m_result", 32'(m_result),     32'd0);
    check("rst_flags",    {29'd0, m_settled, m_overflow, m_timeout}, 32'd0);
    check("rst_s_ready",  32'(s_ready),      32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // ---------- 3-word frame, settle 5, busy 8 then done 0x2A ----------
    cfg_settle = 8'd5; busy_len = 8; done_st = ST_DONE; res_val = 7'h2A; stuck = 1'b0;
    send_frame(3, 19'h00100);
    wait_valid(vcyc);
    check_writes("f3", 3, 19'h00100);
    check("f3_info_data", 32'(info_q[0]), 32'h01403);
    check("f3_latency",   32'(vcyc - info_cyc), 32'd10);
    check("f3_result",    32'(m_result),   32'h2A);
    check("f3_settled",   32'(m_settled),  32'd1);
    check("f3_overflow",  32'(m_overflow), 32'd0);
    check("f3_timeout",   32'(m_timeout),  32'd0);

    // ---------- stall in OUT for 5 cycles ----------
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_m_valid", 32'(m_valid),      32'd1);
      check("stall_result",  32'(m_result),     32'h2A);
      check("stall_settled", 32'(m_settled),    32'd1);
      check("stall_s_ready", 32'(s_ready),      32'd0);
      check("stall_opcode",  32'(cmd_opcode_o), 32'd0);
      check("stall_busy",    32'(busy_o),       32'd1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("rel_m_valid", 32'(m_valid),   32'd0);
    check("rel_busy",    32'(busy_o),    32'd0);
    check("rel_settled", 32'(m_settled), 32'd0);

    // ---------- wrapper ends with status 0, result 0x11 ----------
    cfg_settle = 8'd2; busy_len = 3; done_st = ST_IDLE; res_val = 7'h11;
    send_frame(2, 19'h40000);
    wait_valid(vcyc);
    check_writes("st0", 2, 19'h40000);
    check("st0_info_data", 32'(info_q[0]), 32'h00802);
    check("st0_result",    32'(m_result),  32'h11);
    check("st0_settled",   32'(m_settled), 32'd0);
    check("st0_timeout",   32'(m_timeout), 32'd0);
    release_out();

    // ---------- 130-word frame overflows at 128 ----------
    cfg_settle = 8'd0; busy_len = 4; done_st = ST_DONE; res_val = 7'h55;
    send_frame(130, 19'h00200);
    wait_valid(vcyc);
    check("ovf_wr_count",  32'(wr_q.size()), 32'd128);
    check("ovf_info_data", 32'(info_q[0]),   32'h00080);
    check("ovf_overflow",  32'(m_overflow),  32'd1);
    check("ovf_settled",   32'(m_settled),   32'd1);
    check("ovf_result",    32'(m_result),    32'h55);
    release_out();
    check("ovf_cleared",   32'(m_overflow),  32'd0);

    // ---------- watchdog: status stuck busy ----------
    cfg_settle = 8'd1; stuck = 1'b1;
    send_frame(1, 19'h00007);
    wait_valid(vcyc);
    check("wd_info_data", 32'(info_q[0]), 32'h00401);
    check("wd_latency",   32'(vcyc - info_cyc), 32'(TIMEOUT + 1));
    check("wd_timeout",   32'(m_timeout), 32'd1);
    check("wd_settled",   32'(m_settled), 32'd0);
    release_out();
    check("wd_cleared",   32'(m_timeout), 32'd0);

    // ---------- reset during WAIT_DONE ----------
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    send_frame(1, 19'h00033);
    for (int k = 0; k < 50 && info_q.size() == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rw_in_wait", 32'(busy_o), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("rw_busy",    32'(busy_o),       32'd0);
    check("rw_opcode",  32'(cmd_opcode_o), 32'd0);
    check("rw_m_valid", 32'(m_valid),      32'd0);
    rstn = 1'b1; stuck = 1'b0;
    cfg_settle = 8'd0; busy_len = 0; done_st = ST_DONE; res_val = 7'h3C;
    send_frame(1, 19'h7FFFF);
    wait_valid(vcyc);
    check_writes("post", 1, 19'h7FFFF);
    check("post_info_data", 32'(info_q[0]), 32'h00001);
    check("post_latency",   32'(vcyc - info_cyc), 32'd2);
    check("post_result",    32'(m_result),  32'h3C);
    check("post_settled",   32'(m_settled), 32'd1);
    check("post_timeout",   32'(m_timeout), 32'd0);
    release_out();
    check("post_idle",      32'(busy_o),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_infer_sequencer
